// File: rtl/fsm_mon_pkg.sv
// Shared definitions for monitors attached to serial FSM output streams.
// Contents:
//   state_e       - word assembly state (IDLE, COLLECT)
//   W_DEF         - default word width
//   STUCK_LEN_DEF - default run length that flags a stuck stream
package fsm_mon_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int W_DEF         = 8;
  localparam int STUCK_LEN_DEF = 12;

endpackage

// File: rtl/run_length_det.sv
// Run-length detector for a sampled 1-bit stream. Counts consecutive equal
// samples (word boundaries are irrelevant here) and raises a sticky flag once
// STUCK_LEN equal samples have been seen in a row.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   in_bit       - sampled bit
//   in_en        - in_bit is sampled this edge
//   clr          - clears stuck and run_cnt (a same-cycle set wins)
//   stuck        - sticky flag
//   run_cnt      - current run length, saturating at STUCK_LEN
module run_length_det
  import fsm_mon_pkg::*;
#(
  parameter int STUCK_LEN = STUCK_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_en,
  input  logic       clr,
  output logic       stuck,
  output logic [7:0] run_cnt
);

  localparam logic [7:0] RUN_MAX = 8'(STUCK_LEN);

  logic [7:0] run_cnt_q, run_cnt_d;
  logic       last_bit_q, last_bit_d;
  logic       stuck_q, stuck_d;
  logic [7:0] run_upd;
  logic       hit;

  always_comb begin
    // A cleared counter (0) always restarts the run, whatever last_bit holds.
    if (run_cnt_q == 8'd0 || in_bit != last_bit_q) begin
      run_upd = 8'd1;
    end else if (run_cnt_q == RUN_MAX) begin
      run_upd = RUN_MAX;
    end else begin
      run_upd = run_cnt_q + 8'd1;
    end
    hit = in_en && (run_upd == RUN_MAX);

    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    stuck_d    = stuck_q;
    if (in_en) begin
      last_bit_d = in_bit;
    end
    // Setting takes priority over clr; the counter keeps its updated value.
    if (hit) begin
      stuck_d   = 1'b1;
      run_cnt_d = run_upd;
    end else if (clr) begin
      stuck_d   = 1'b0;
      run_cnt_d = 8'd0;
    end else if (in_en) begin
      run_cnt_d = run_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q  <= 8'd0;
      last_bit_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      stuck_q    <= stuck_d;
    end
  end

  assign stuck   = stuck_q;
  assign run_cnt = run_cnt_q;

endmodule

// File: rtl/fsm_out_deframer.sv
// Deframer for the serial output bit of a monitored FSM. Packs sampled bits
// MSB-first into W-bit words, reports each word with its ones-count over a
// valid/ready handshake, counts delivered words, and raises sticky flags for
// dropped words (overflow) and a frozen output stream (stuck).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_bit, in_en        - serial bit and its sample enable
//   clr                  - clears overflow/stuck only
//   word_out, ones_out   - held word and its number of 1s
//   word_valid/ready     - output handshake
//   overflow, stuck      - sticky status flags
//   word_cnt             - delivered words, wraps at 16 bits
module fsm_out_deframer
  import fsm_mon_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int STUCK_LEN = STUCK_LEN_DEF,
  parameter int CW        = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_bit,
  input  logic          in_en,
  input  logic          clr,
  output logic [W-1:0]  word_out,
  output logic [CW-1:0] ones_out,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          overflow,
  output logic          stuck,
  output logic [15:0]   word_cnt
);

  state_e        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] ones_acc_q, ones_acc_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic          accept;
  logic          complete;
  logic [CW-1:0] bit_next;
  logic [CW-1:0] ones_next;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    ones_acc_d = ones_acc_q;
    word_d     = word_q;
    ones_d     = ones_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    word_cnt_d = word_cnt_q;
    complete   = 1'b0;

    accept   = valid_q && word_ready;
    bit_next = bit_cnt_q + CW'(1);
    // The running ones-count restarts with the first bit of every word.
    ones_next = ((state_q == IDLE) ? '0 : ones_acc_q) + CW'(in_bit);

    if (in_en) begin
      sr_d = {sr_q[W-2:0], in_bit};
      if (bit_next == CW'(W)) begin
        complete   = 1'b1;
        bit_cnt_d  = '0;
        ones_acc_d = '0;
        state_d    = IDLE;
      end else begin
        bit_cnt_d  = bit_next;
        ones_acc_d = ones_next;
        state_d    = COLLECT;
      end
    end

    if (accept) begin
      word_cnt_d = word_cnt_q + 16'd1;
      valid_d    = 1'b0;
    end

    // A completing word may replace the held one only if the slot is free or
    // being emptied on this very edge; otherwise it is dropped.
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = {sr_q[W-2:0], in_bit};
        ones_d  = ones_next;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (clr && !(complete && valid_q && !word_ready)) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      ones_acc_q <= '0;
      word_q     <= '0;
      ones_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_acc_q <= ones_acc_d;
      word_q     <= word_d;
      ones_q     <= ones_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  run_length_det #(
    .STUCK_LEN(STUCK_LEN)
  ) u_run_det (
    .clk    (clk),
    .reset  (reset),
    .in_bit (in_bit),
    .in_en  (in_en),
    .clr    (clr),
    .stuck  (stuck),
    .run_cnt()
  );

  assign word_out   = word_q;
  assign ones_out   = ones_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fsm_out_deframer.sv
module tb_fsm_out_deframer;

  localparam int W  = 8;
  localparam int SL = 12;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_en = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  word_out;
  logic [CW-1:0] ones_out;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          overflow;
  logic          stuck;
  logic [15:0]   word_cnt;

  int n_pass = 0;
  int n_total = 0;

  fsm_out_deframer #(.W(W), .STUCK_LEN(SL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_en     (in_en),
    .clr       (clr),
    .word_out  (word_out),
    .ones_out  (ones_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .overflow  (overflow),
    .stuck     (stuck),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bits are collected in a queue and packed when W arrive;
  // the stuck detector is a plain count of trailing equal samples.
  bit            pend[$];
  logic [W-1:0]  m_word;
  logic [CW-1:0] m_ones;
  logic          m_valid, m_ovf, m_stuck, m_last;
  logic [15:0]   m_cnt;
  int            m_run;

  task automatic model_update(input logic b, input logic en, input logic rdy,
                              input logic c, input logic rst);
    logic [W-1:0] w;
    logic done, acc, drop;
    int nrun;
    if (rst) begin
      pend.delete();
      m_word = '0; m_ones = '0; m_valid = 1'b0; m_ovf = 1'b0;
      m_stuck = 1'b0; m_last = 1'b0; m_cnt = 16'd0; m_run = 0;
      return;
    end
    done = 1'b0; drop = 1'b0; w = '0;
    acc = m_valid && rdy;
    nrun = m_run;
    if (en) begin
      pend.push_back(b);
      if (pend.size() == W) begin
        for (int i = 0; i < W; i++) w = {w[W-2:0], logic'(pend[i])};
        pend.delete();
        done = 1'b1;
      end
      nrun = (m_run == 0 || b != m_last) ? 1 : m_run + 1;
      m_last = b;
    end
    if (en && nrun >= SL) begin
      m_stuck = 1'b1; m_run = nrun;
    end else if (c) begin
      m_stuck = 1'b0; m_run = 0;
    end else if (en) begin
      m_run = nrun;
    end
    if (acc) begin
      m_cnt = m_cnt + 16'd1;
      m_valid = 1'b0;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word = w; m_ones = CW'($countones(w)); m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic step(input logic b, input logic en, input logic rdy, input logic c);
    in_bit = b; in_en = en; word_ready = rdy; clr = c;
    @(posedge clk);
    model_update(b, en, rdy, c, reset);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({word_out, ones_out, word_valid, overflow, stuck, word_cnt} !== '0) begin
      $display("FAIL reset_state: got word=%h ones=%0d v=%b ovf=%b stuck=%b cnt=%0d, need all 0",
               word_out, ones_out, word_valid, overflow, stuck, word_cnt);
    end else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'hB2;
    do_reset();
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b1, 1'b0);
    n_total++;
    if (word_valid !== 1'b1 || word_out !== 8'hB2 || ones_out !== CW'(4)) begin
      $display("FAIL basic_word: got v=%b word=%h ones=%0d, need v=1 word=b2 ones=4",
               word_valid, word_out, ones_out);
    end else n_pass++;
    n_total++;
    if (word_cnt !== 16'd0) begin
      $display("FAIL basic_cnt_before: got %0d need 0", word_cnt);
    end else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (word_valid !== 1'b0 || word_cnt !== 16'd1) begin
      $display("FAIL basic_accept: got v=%b cnt=%0d, need v=0 cnt=1", word_valid, word_cnt);
    end else n_pass++;
    $display("test_basic word=%h ones=%0d", 8'hB2, 4);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (word_out !== 8'hFF || ones_out !== CW'(8) || overflow !== 1'b1 || word_valid !== 1'b1) begin
      $display("FAIL overflow_hold: got word=%h ones=%0d ovf=%b v=%b, need word=ff ones=8 ovf=1 v=1",
               word_out, ones_out, overflow, word_valid);
    end else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (word_cnt !== 16'd1 || word_valid !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL overflow_drain: got cnt=%0d v=%b ovf=%b, need cnt=1 v=0 ovf=1",
               word_cnt, word_valid, overflow);
    end else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clr: got %b need 0", overflow);
    end else n_pass++;
    $display("test_overflow held=ff dropped=00");
  endtask

  task automatic test_stuck();
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (stuck !== 1'b0) begin
      $display("FAIL stuck_early: got %b need 0 after 11 samples", stuck);
    end else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (stuck !== 1'b1) begin
      $display("FAIL stuck_set: got %b need 1 after 12 samples", stuck);
    end else n_pass++;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (stuck !== 1'b0 || word_cnt !== 16'd1) begin
      $display("FAIL stuck_clr: got stuck=%b cnt=%0d, need stuck=0 cnt=1", stuck, word_cnt);
    end else n_pass++;
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (stuck !== 1'b0) begin
      $display("FAIL stuck_broken_run: got %b need 0", stuck);
    end else n_pass++;
    $display("test_stuck done");
  endtask

  task automatic test_toggle();
    logic [7:0] pat = 8'h5C;
    int words = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(pat[7 - i / 2], 1'b1, 1'b1, 1'b0);
      else step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      if (word_valid === 1'b1) words++;
      if (i == 14) begin
        n_total++;
        if (word_valid !== 1'b1 || word_out !== 8'h5C || ones_out !== CW'(4)) begin
          $display("FAIL toggle_word: got v=%b word=%h ones=%0d, need v=1 word=5c ones=4",
                   word_valid, word_out, ones_out);
        end else n_pass++;
      end
    end
    n_total++;
    if (words != 1 || word_cnt !== 16'd1) begin
      $display("FAIL toggle_count: got words=%0d cnt=%0d, need 1 and 1", words, word_cnt);
    end else n_pass++;
    $display("test_toggle word=5c");
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'hA7;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    n_total++;
    if (word_valid !== 1'b0 || overflow !== 1'b0 || stuck !== 1'b0 || word_cnt !== 16'd0) begin
      $display("FAIL midreset_flags: got v=%b ovf=%b stuck=%b cnt=%0d, need all 0",
               word_valid, overflow, stuck, word_cnt);
    end else n_pass++;
    for (int i = 7; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
    n_total++;
    if (word_valid !== 1'b1 || word_out !== 8'hA7 || ones_out !== CW'(5)) begin
      $display("FAIL midreset_word: got v=%b word=%h ones=%0d, need v=1 word=a7 ones=5",
               word_valid, word_out, ones_out);
    end else n_pass++;
    $display("test_reset_mid word=a7");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a = 8'hC3;
    logic [7:0] b = 8'h3C;
    do_reset();
    for (int i = 7; i >= 0; i--) step(a[i], 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) step(b[i], 1'b1, 1'b0, 1'b0);
    n_total++;
    if (word_out !== 8'hC3 || word_valid !== 1'b1) begin
      $display("FAIL b2b_held: got word=%h v=%b, need c3 v=1", word_out, word_valid);
    end else n_pass++;
    step(b[0], 1'b1, 1'b1, 1'b0);
    n_total++;
    if (word_out !== 8'h3C || word_valid !== 1'b1 || overflow !== 1'b0 || word_cnt !== 16'd1) begin
      $display("FAIL b2b_swap: got word=%h v=%b ovf=%b cnt=%0d, need 3c v=1 ovf=0 cnt=1",
               word_out, word_valid, overflow, word_cnt);
    end else n_pass++;
    $display("test_back_to_back words=c3,3c");
  endtask

  task automatic test_random();
    logic b = 1'b0;
    logic en, rdy, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) b = ~b;
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      c   = ($urandom_range(0, 29) == 0);
      if (m_valid && rdy) $display("random txn %0d: word=%h ones=%0d", i, m_word, m_ones);
      step(b, en, rdy, c);
      n_total++;
      if (word_valid !== m_valid || word_out !== m_word || ones_out !== m_ones) begin
        $display("FAIL rand_word cyc %0d: got v=%b w=%h o=%0d, need v=%b w=%h o=%0d",
                 i, word_valid, word_out, ones_out, m_valid, m_word, m_ones);
      end else n_pass++;
      n_total++;
      if (overflow !== m_ovf || stuck !== m_stuck || word_cnt !== m_cnt) begin
        $display("FAIL rand_flags cyc %0d: got ovf=%b stuck=%b cnt=%0d, need ovf=%b stuck=%b cnt=%0d",
                 i, overflow, stuck, word_cnt, m_ovf, m_stuck, m_cnt);
      end else n_pass++;
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stuck();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
